spi_simple_slave: RTL
=====================

SPI_SIMPLE_SLAVE -- requirements
Module: spi_simple_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word length in bits (>=2).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for sclk/mosi/cs_n (>=2).
REQ-003 Single clock; reset is asynchronous and active-low: clk and rst_n.
REQ-004 clk  in  1  system clock; all state on posedge.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 sclk  in  1  SPI clock from master, asynchronous to clk.
REQ-007 mosi  in  1  master-out data, asynchronous.
REQ-008 cs_n  in  1  active-low chip select, asynchronous.
REQ-009 miso  out  1  slave-out data.
REQ-010 cpol, cpha  in  1 each  SPI mode; static while cs_n low.
REQ-011 tx_data  in  DATA_WIDTH  next word to transmit.
REQ-012 tx_valid  in  1  tx_data valid.
REQ-013 tx_ready  out  1  TX buffer empty; word accepted when tx_valid && tx_ready.
REQ-014 rx_data  out  DATA_WIDTH  last complete received word.
REQ-015 rx_valid  out  1  one-cycle pulse, rx_data updated.
REQ-016 tx_underrun  out  1  one-cycle pulse, word loaded while TX buffer empty.
REQ-017 busy  out  1  high in state SHIFT.

Function
REQ-018 sclk, mosi, cs_n each SHALL pass through SYNC_STAGES flops; all later logic uses synced versions only.
REQ-019 Edge detect: registered previous synced sclk; edge = prev != current; edges ignored unless state SHIFT.
REQ-020 Sample edge = rising when cpol==cpha, falling otherwise; change edge = the other.
REQ-021 States: IDLE, SHIFT. IDLE->SHIFT on synced cs_n 1->0; SHIFT->IDLE on synced cs_n 0->1.
REQ-022 Load (IDLE->SHIFT and word completion): tx shift reg <= TX buffer if full, else all zeros plus tx_underrun pulse; buffer marked empty.
REQ-023 Load uses buffer state at cycle start; same-cycle tx_valid&&tx_ready fills buffer for next word.
REQ-024 Skip flag: set on load when cpha=1 (cs load) or always (completion load); first change edge with skip set clears flag, no shift.
REQ-025 Other change edges in SHIFT: tx shift reg shifts left one, LSB fill 0.
REQ-026 miso = tx shift reg MSB in SHIFT, 0 in IDLE.
REQ-027 Sample edge: rx shift reg <= {rx_shift[DATA_WIDTH-2:0], synced mosi}; bit_cnt++ (width clog2(DATA_WIDTH)).
REQ-028 Sample with bit_cnt==DATA_WIDTH-1: rx_data <= completed word (including this bit), rx_valid=1 next cycle only, bit_cnt<=0, completion load.
REQ-029 Multiple words per cs_n frame SHALL be supported back-to-back via REQ-028.
REQ-030 cs_n rises mid-word: partial word discarded, no rx_valid, bit_cnt<=0, skip cleared, rx_data unchanged, buffer unchanged.
REQ-031 Latency: rx_valid high SYNC_STAGES+2 clk cycles after sclk pin sample edge.
REQ-032 Supported timing: sclk half-period and cs_n-to-first-edge >= SYNC_STAGES+2 clk periods; faster is out of scope.
REQ-033 tx_ready = !buffer_full in all states.

Reset
REQ-034 On rst_n low: state IDLE, bit_cnt 0, shift regs 0, buffer empty, skip 0, sync flops sclk 0 / mosi 0 / cs_n 1.
REQ-035 Output reset values: miso 0, tx_ready 1, rx_data 0, rx_valid 0, tx_underrun 0, busy 0.
REQ-036 Reset mid-frame: abort immediately; after release, resume only on new synced cs_n falling edge.

Verification
REQ-037 Mode 0, buffer 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data 0x3C, one rx_valid pulse, tx_ready high after load.
REQ-038 Modes 1/2/3, tx 0x81, rx 0x7E -> master receives 0x81, rx_data 0x7E, in each mode.
REQ-039 Empty buffer at cs_n fall -> tx_underrun one pulse, miso all 0, rx still 0x55 when sent.
REQ-040 Two words one frame, mode 0, buffers 0x12 then 0x34 written after first load -> master gets 0x12,0x34; two rx_valid pulses.
REQ-041 cs_n rises after 5 bits -> no rx_valid, rx_data unchanged; next full frame 0xF0 received correctly.
REQ-042 rst_n pulsed mid-frame -> outputs at REQ-035 values; next frame 0x99 received correctly.

Source files
------------

// File: rtl/spi_simple_slave.sv
// SPI slave: synchronises the SPI pins into clk, shifts DATA_WIDTH-bit words in all four modes,
// with a one-word transmit buffer and per-word receive strobe.
module spi_simple_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  cs_n,
    output logic                  miso,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    cs_prev_q, cs_prev_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic                    skip_q, skip_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    underrun_q, underrun_d;
    logic                    miso_q, miso_d;
    logic                    busy_q, busy_d;
    logic                    tx_ready_q, tx_ready_d;

    logic sclk_s, mosi_s, cs_s;
    logic cs_fall_s, cs_rise_s, sclk_edge_s, sample_edge_s, change_edge_s;
    logic load_s;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign cs_fall_s = cs_prev_q & ~cs_s;
    assign cs_rise_s = ~cs_prev_q & cs_s;
    assign sclk_edge_s   = (sclk_prev_q != sclk_s) && (state_q == ST_SHIFT);
    // Rising edge samples when cpol==cpha; the opposite edge drives miso.
    assign sample_edge_s = sclk_edge_s && (sclk_s == (cpol == cpha));
    assign change_edge_s = sclk_edge_s && (sclk_s != (cpol == cpha));

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) state_d = ST_SHIFT;
                else           state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (cs_rise_s) state_d = ST_IDLE;
                else           state_d = ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift datapath; a load reads the buffer as it stood at the start of the cycle.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        skip_d     = skip_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        load_s     = 1'b0;

        if (state_q == ST_IDLE) begin
            if (cs_fall_s) begin
                load_s    = 1'b1;
                skip_d    = cpha;
                bit_cnt_d = '0;
            end else begin
                skip_d = 1'b0;
            end
        end else if (cs_rise_s) begin
            bit_cnt_d = '0;
            skip_d    = 1'b0;
        end else if (sample_edge_s) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
                rx_data_d  = rx_shift_d;
                rx_valid_d = 1'b1;
                bit_cnt_d  = '0;
                load_s     = 1'b1;
                skip_d     = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else if (change_edge_s) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        if (load_s) begin
            buf_full_d = 1'b0;
            if (buf_full_q) begin
                tx_shift_d = buf_q;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end else begin
            buf_full_d = buf_full_q;
        end

        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end else begin
            buf_d = buf_q;
        end
    end

    always_comb begin
        busy_d     = (state_d == ST_SHIFT);
        miso_d     = (state_d == ST_SHIFT) ? tx_shift_d[DATA_WIDTH-1] : 1'b0;
        tx_ready_d = ~buf_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            skip_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            skip_q     <= skip_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign miso        = miso_q;
    assign busy        = busy_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule
